// File: rtl/vector_unit_pkg.sv
// Shared types and constants for the vector unit accumulate/saturate path.
package vector_unit_pkg;

    typedef enum logic [1:0] {
        VACC_SATURATE       = 2'd0,
        VACC_ACCUMULATE     = 2'd1,
        VACC_ACCUMULATE_SAT = 2'd2
    } vacc_op_t;

    typedef enum logic [1:0] {
        BIT8  = 2'd0,
        BIT16 = 2'd1,
        BIT32 = 2'd2
    } esize_t;

    localparam logic [7:0]  Q7_MAX  = 8'h7F;
    localparam logic [7:0]  Q7_MIN  = 8'h80;
    localparam logic [15:0] Q15_MAX = 16'h7FFF;
    localparam logic [15:0] Q15_MIN = 16'h8000;
    localparam logic [31:0] Q31_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q31_MIN = 32'h8000_0000;

    function automatic int lane_count(input esize_t es, input int xlen);
        case (es)
            BIT8:    return xlen / 8;
            BIT16:   return xlen / 16;
            BIT32:   return xlen / 32;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/vector_lane_saturator.sv
// Single-lane Q-format narrowing: optional round, arithmetic shift by N-1, clamp.
// Rounding (round-half-up) is present only when VACC_ROUNDING_EN is defined.
module vector_lane_saturator #(
    parameter int N = 8
) (
    input  logic [2*N-1:0] product_i,
    output logic [N-1:0]   lane_o,
    output logic           overflow_o
);
    // One guard bit so the rounding add can never wrap the product.
    localparam int W = 2 * N + 1;

    logic [W-1:0] ext;
    logic [W-1:0] rounded;
    logic [W-1:0] shifted;

    assign ext = {product_i[2*N-1], product_i};

`ifdef VACC_ROUNDING_EN
    localparam logic [W-1:0] RND = W'(1) << (N - 2);
    assign rounded = ext + RND;
`else
    assign rounded = ext;
`endif

    assign shifted    = $signed(rounded) >>> (N - 1);
    assign overflow_o = !((&shifted[W-1:N-1]) || (~|shifted[W-1:N-1]));

    always_comb begin
        lane_o = shifted[N-1:0];
        if (overflow_o) begin
            lane_o = rounded[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end

endmodule

// File: rtl/vector_mac_accumulator.sv
// Two-stage accumulate/saturate stage between the vector multiplier and writeback.
// Build option: VACC_ROUNDING_EN enables round-half-up in the saturate lanes.
module vector_mac_accumulator
    import vector_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  vacc_op_t          operation_i,
    input  esize_t            element_size_i,
    input  logic [2*XLEN-1:0] vmul_result_i,
    input  logic [XLEN-1:0]   reg_destination_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic              overflow_o,
    input  logic              ov_clear_i,
    output logic              ov_sticky_o
);
    localparam int L8    = lane_count(BIT8, XLEN);
    localparam int L16   = lane_count(BIT16, XLEN);
    localparam int L32   = lane_count(BIT32, XLEN);
    // Wide enough for every lane sum plus rd without loss.
    localparam int ACC_W = 2 * XLEN + 2;

    logic [XLEN-1:0]  sat8, sat16, sat32;
    logic [L8-1:0]    ovf8;
    logic [L16-1:0]   ovf16;
    logic [L32-1:0]   ovf32;
    logic [ACC_W-1:0] ext8  [L8];
    logic [ACC_W-1:0] ext16 [L16];
    logic [ACC_W-1:0] ext32 [L32];

    for (genvar g = 0; g < L8; g++) begin : g_l8
        vector_lane_saturator #(.N(8)) u_sat (
            .product_i  (vmul_result_i[16*g +: 16]),
            .lane_o     (sat8[8*g +: 8]),
            .overflow_o (ovf8[g])
        );
        assign ext8[g] = {{(ACC_W-16){vmul_result_i[16*g+15]}}, vmul_result_i[16*g +: 16]};
    end

    for (genvar g = 0; g < L16; g++) begin : g_l16
        vector_lane_saturator #(.N(16)) u_sat (
            .product_i  (vmul_result_i[32*g +: 32]),
            .lane_o     (sat16[16*g +: 16]),
            .overflow_o (ovf16[g])
        );
        assign ext16[g] = {{(ACC_W-32){vmul_result_i[32*g+31]}}, vmul_result_i[32*g +: 32]};
    end

    for (genvar g = 0; g < L32; g++) begin : g_l32
        vector_lane_saturator #(.N(32)) u_sat (
            .product_i  (vmul_result_i[64*g +: 64]),
            .lane_o     (sat32[32*g +: 32]),
            .overflow_o (ovf32[g])
        );
        assign ext32[g] = {{(ACC_W-64){vmul_result_i[64*g+63]}}, vmul_result_i[64*g +: 64]};
    end

    logic [XLEN-1:0]  sat_d;
    logic             sat_ovf_d;
    logic [ACC_W-1:0] psum0_d, psum1_d;

    // Even and odd lanes are summed separately; S2 folds them with rd.
    always_comb begin
        sat_d     = '0;
        sat_ovf_d = 1'b0;
        psum0_d   = '0;
        psum1_d   = '0;
        case (element_size_i)
            BIT8: begin
                sat_d     = sat8;
                sat_ovf_d = |ovf8;
                for (int i = 0; i < L8; i++) begin
                    if (i[0]) psum1_d = psum1_d + ext8[i];
                    else      psum0_d = psum0_d + ext8[i];
                end
            end
            BIT16: begin
                sat_d     = sat16;
                sat_ovf_d = |ovf16;
                for (int i = 0; i < L16; i++) begin
                    if (i[0]) psum1_d = psum1_d + ext16[i];
                    else      psum0_d = psum0_d + ext16[i];
                end
            end
            BIT32: begin
                sat_d     = sat32;
                sat_ovf_d = |ovf32;
                for (int i = 0; i < L32; i++) begin
                    if (i[0]) psum1_d = psum1_d + ext32[i];
                    else      psum0_d = psum0_d + ext32[i];
                end
            end
            default: ;
        endcase
    end

    logic             s1_valid_q;
    vacc_op_t         s1_op_q;
    logic [XLEN-1:0]  s1_sat_q;
    logic             s1_sat_ovf_q;
    logic [ACC_W-1:0] s1_psum0_q, s1_psum1_q;
    logic [XLEN-1:0]  s1_rd_q;
    logic             valid_q;
    logic [XLEN-1:0]  result_q;
    logic             overflow_q;
    logic             sticky_q;

    logic s2_adv, s1_adv;
    assign s2_adv  = !valid_q || ready_i;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign ready_o = s1_adv;

    logic [ACC_W-1:0] total;
    logic             fits;
    logic [XLEN-1:0]  res_d;
    logic             ov_d;

    always_comb begin
        total = s1_psum0_q + s1_psum1_q + {{(ACC_W-XLEN){s1_rd_q[XLEN-1]}}, s1_rd_q};
        fits  = (&total[ACC_W-1:XLEN-1]) || (~|total[ACC_W-1:XLEN-1]);
        res_d = '0;
        ov_d  = 1'b0;
        case (s1_op_q)
            VACC_SATURATE: begin
                res_d = s1_sat_q;
                ov_d  = s1_sat_ovf_q;
            end
            VACC_ACCUMULATE: res_d = total[XLEN-1:0];
            VACC_ACCUMULATE_SAT: begin
                if (fits)                res_d = total[XLEN-1:0];
                else if (total[ACC_W-1]) res_d = {1'b1, {(XLEN-1){1'b0}}};
                else                     res_d = {1'b0, {(XLEN-1){1'b1}}};
                ov_d = !fits;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= VACC_SATURATE;
            s1_sat_q     <= '0;
            s1_sat_ovf_q <= 1'b0;
            s1_psum0_q   <= '0;
            s1_psum1_q   <= '0;
            s1_rd_q      <= '0;
            valid_q      <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            if (flush_i)     s1_valid_q <= 1'b0;
            else if (s1_adv) s1_valid_q <= valid_i;

            if (s1_adv && valid_i && !flush_i) begin
                s1_op_q      <= operation_i;
                s1_sat_q     <= sat_d;
                s1_sat_ovf_q <= sat_ovf_d;
                s1_psum0_q   <= psum0_d;
                s1_psum1_q   <= psum1_d;
                s1_rd_q      <= reg_destination_i;
            end

            if (flush_i)     valid_q <= 1'b0;
            else if (s2_adv) valid_q <= s1_valid_q;

            if (s2_adv && s1_valid_q && !flush_i) begin
                result_q   <= res_d;
                overflow_q <= ov_d;
            end

            // A set on the same edge as a clear must win.
            if (valid_q && ready_i && overflow_q) sticky_q <= 1'b1;
            else if (ov_clear_i)                  sticky_q <= 1'b0;
        end
    end

    assign valid_o     = valid_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;
    assign ov_sticky_o = sticky_q;

endmodule

// File: doc/vector_mac_accumulator.md
# vector_mac_accumulator

Parametrised, pipelined successor of the vector unit's combinational accumulate/saturate stage. Takes the packed double-width product vector from the vector multiplier plus the destination register. Produces one of three results:
- a Q-format saturated narrow vector;
- a horizontal sum accumulated into rd, wrapping;
- the same sum accumulated into rd, saturating.

The block sits between the vector multiplier and the vector unit writeback, with valid/ready handshakes on both sides and a sticky overflow flag for the DSP status CSR.

## Interface
Parameters:
- XLEN, 32, register width; legal values 32 or 64. Lane width N is 8, 16 or 32, so lane count is XLEN/N.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous pipeline kill
- valid_i  in  1  input operands valid
- ready_o  out  1  block can accept this cycle
- operation_i  in  vacc_op_t  VACC_SATURATE / VACC_ACCUMULATE / VACC_ACCUMULATE_SAT
- element_size_i  in  esize_t  BIT8 / BIT16 / BIT32
- vmul_result_i  in  2*XLEN  packed products, lane i at bits [2N*i +: 2N]
- reg_destination_i  in  XLEN  accumulator source rd
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts
- result_o  out  XLEN  result
- overflow_o  out  1  this result saturated
- ov_clear_i  in  1  clear sticky flag
- ov_sticky_o  out  1  sticky overflow

## Operation
- **VACC_SATURATE**, per lane:
  - Shift: p >>> (N-1), arithmetic.
  - Saturate if bits [2N-1:N-1] of the shifted value are not all equal.
  - Clamp value: positive → 2^(N-1)-1 (0x7F / 0x7FFF / 0x7FFF_FFFF); negative → -2^(N-1).
  - Every bit of the upper 2N bits is checked, not just one.
  - The saturated lanes are packed into result_o.
- **VACC_ACCUMULATE**: sign-extend every 2N-bit lane product. The internal sum width is 2N + log2(XLEN/N) + 1. Result is rd + Σlanes truncated to XLEN (wraps). overflow_o = 0.
- **VACC_ACCUMULATE_SAT**: same sum, computed at full width plus rd. Clamp to [-2^(XLEN-1), 2^(XLEN-1)-1]. overflow_o = 1 if clamped.
- **overflow_o**: OR of per-lane saturation events for the result.
- **ov_sticky_o**:
  - Set on the cycle valid_o && ready_i && overflow_o.
  - Cleared by ov_clear_i.
  - Simultaneous set and clear → set wins.
  - flush_i does not affect it.

## Timing
- Pipeline stages:
  - S1 registers the per-lane shifted/rounded values and the pairwise partial sums.
  - S2 registers the final add with rd, the clamp, and overflow_o.
- Latency is 2 cycles from input handshake (valid_i && ready_o) to valid_o. Throughput is 1 per cycle with no backpressure.
- Handshake rules:
  - S2 advances when !valid_o || ready_i.
  - S1 advances when S1 is empty or S2 advances.
  - ready_o = S1 empty || S2 advances (combinational, no dependency on valid_i).
  - While valid_o && !ready_i, result_o, overflow_o and valid_o are held stable.
- Results leave in order.
- Reset values: valid_o=0, result_o=0, overflow_o=0, ov_sticky_o=0, both stage valid bits=0. ready_o=1 after reset.
- flush_i clears both stage valid bits in the next cycle. An input presented in the same cycle as flush_i is dropped.
- Reset asserted mid-operation discards all in-flight data immediately.

## Configuration
- Macro `VACC_ROUNDING_EN`:
  - Defined: VACC_SATURATE adds 2^(N-2) to each lane product before the shift (round-half-up). The saturation check applies to the rounded value.
  - Undefined: truncation only, no adder in the lane path.
- Accumulate modes are unaffected by the macro.

## Structure
- Add to vector_unit_pkg:
  - vacc_op_t (2-bit enum);
  - the Q7/Q15/Q31 max/min constants;
  - a function returning the lane count from esize_t and XLEN.
- Sub-module vector_lane_saturator:
  - parameter N;
  - performs round, shift, saturate and the overflow bit for a single lane;
  - instantiated XLEN/8 + XLEN/16 + XLEN/32 times, with a mux on element_size_i.

## Test plan
- BIT16 SATURATE, lanes 0x4000_0000 and 0x0000_8000 → result 0x0001_7FFF, overflow_o=1, ov_sticky_o=1 one cycle after the output handshake.
- BIT8 ACCUMULATE, four lanes 0xFFFF (-1), rd=0x0000_0010 → 0x0000_000C, overflow_o=0. Same lanes 0x0010 with rd=0x100 → 0x0000_0140.
- BIT32 ACCUMULATE_SAT, product 0x0000_0000_7FFF_FFFF, rd=1 → 0x7FFF_FFFF, overflow_o=1. The same inputs in ACCUMULATE → 0x8000_0000, overflow_o=0.
- BIT16 SATURATE, lane 0x0000_4000: with VACC_ROUNDING_EN → lane 0x0001; without → 0x0000.
- Backpressure: 4 back-to-back inputs with ready_i=0 for 3 cycles:
  - ready_o drops after 2 are accepted;
  - the held result_o stays stable;
  - all 4 results emerge in order once ready_i=1.
- flush_i with 2 operations in flight → no valid_o. ov_clear_i in the same cycle as an overflowing output handshake → ov_sticky_o stays 1. rst_n_i pulsed low mid-stream → all outputs 0 asynchronously.
